mapping_req_arbiter: RTL and testbench

Shares the single hashed-paging mapping lookup pipeline between the read and write request streams (72-bit AXI-Stream).
- Round-robin arbitrates in_read/in_write into one lookup request stream.
- Records the source of each issued request in an order FIFO.
- Steers the in-order lookup responses back to out_read or out_write.
- Provides a pause/idle handshake so control software can quiesce the pipeline before reconfiguring the mapping table.

---
 rtl/mapping_req_arbiter.sv | 138 +++++++++++++
 tb/tb_mapping_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapping_req_arbiter.sv
// Round-robin arbiter sharing one mapping-lookup pipeline between read and write request
// streams; an order FIFO steers the in-order responses back to their source.
module mapping_req_arbiter #(
  parameter int unsigned DATA_W          = 72,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] in_read_tdata,
  input  logic              in_read_tvalid,
  output logic              in_read_tready,
  input  logic [DATA_W-1:0] in_write_tdata,
  input  logic              in_write_tvalid,
  output logic              in_write_tready,
  output logic [DATA_W-1:0] lookup_req_tdata,
  output logic              lookup_req_tvalid,
  input  logic              lookup_req_tready,
  input  logic [DATA_W-1:0] lookup_rsp_tdata,
  input  logic              lookup_rsp_tvalid,
  output logic              lookup_rsp_tready,
  output logic [DATA_W-1:0] out_read_tdata,
  output logic              out_read_tvalid,
  input  logic              out_read_tready,
  output logic [DATA_W-1:0] out_write_tdata,
  output logic              out_write_tvalid,
  input  logic              out_write_tready,
  input  logic              cfg_pause,
  output logic              idle,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_unexp_rsp
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  logic                       req_valid_q, req_valid_d;
  logic [DATA_W-1:0]          req_data_q, req_data_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d;
  logic                       rr_q, rr_d;  // 1: favour write on the next contended cycle
  logic                       err_q, err_d;
  logic                       idle_q, idle_d;

  logic can_accept, grant_rd, grant_wr, push, push_src;
  logic fifo_empty, head, pop;

  // Request side: grant is purely combinational from tvalid and the RR pointer.
  always_comb begin
    can_accept = ap_rst_n && (!req_valid_q || lookup_req_tready) &&
                 (outstanding_q < MaxCnt) && !cfg_pause;
    grant_rd   = in_read_tvalid && (!in_write_tvalid || !rr_q);
    grant_wr   = in_write_tvalid && (!in_read_tvalid || rr_q);
    in_read_tready  = can_accept && grant_rd;
    in_write_tready = can_accept && grant_wr;
    push       = can_accept && (grant_rd || grant_wr);
    push_src   = grant_wr;
  end

  // FIFO occupancy always equals the outstanding count, so the count doubles as empty flag.
  always_comb begin
    fifo_empty        = (outstanding_q == '0);
    head              = fifo_q[rd_ptr_q];
    lookup_rsp_tready = ap_rst_n && !fifo_empty && (head ? out_write_tready : out_read_tready);
    out_read_tvalid   = lookup_rsp_tvalid && !fifo_empty && !head;
    out_write_tvalid  = lookup_rsp_tvalid && !fifo_empty && head;
    out_read_tdata    = lookup_rsp_tdata;
    out_write_tdata   = lookup_rsp_tdata;
    pop               = lookup_rsp_tvalid && lookup_rsp_tready;
  end

  always_comb begin
    req_valid_d   = req_valid_q;
    req_data_d    = req_data_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    rr_d          = rr_q;

    if (push) begin
      req_valid_d      = 1'b1;
      req_data_d       = push_src ? in_write_tdata : in_read_tdata;
      fifo_d[wr_ptr_q] = push_src;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      rr_d             = !push_src;
    end else if (lookup_req_tready) begin
      req_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    err_d  = err_q || (lookup_rsp_tvalid && fifo_empty);
    // Registered from next-state so idle tracks the current slot/count without extra lag.
    idle_d = !req_valid_d && (outstanding_d == '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_valid_q   <= 1'b0;
      req_data_q    <= '0;
      fifo_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      rr_q          <= 1'b0;
      err_q         <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      req_valid_q   <= req_valid_d;
      req_data_q    <= req_data_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      rr_q          <= rr_d;
      err_q         <= err_d;
      idle_q        <= idle_d;
    end
  end

  assign lookup_req_tvalid = req_valid_q;
  assign lookup_req_tdata  = req_data_q;
  assign outstanding       = outstanding_q;
  assign err_unexp_rsp     = err_q;
  assign idle              = idle_q;

endmodule

// File: tb/tb_mapping_req_arbiter.sv
// Directed self-checking bench for mapping_req_arbiter: arbitration, order steering,
// backpressure, outstanding limit, unexpected responses and pause/idle.
module tb_mapping_req_arbiter;

  localparam int unsigned DATA_W = 72;
  localparam int unsigned CNT_W  = 5;

  logic              ap_clk, ap_rst_n;
  logic [DATA_W-1:0] in_read_tdata, in_write_tdata;
  logic              in_read_tvalid, in_read_tready, in_write_tvalid, in_write_tready;
  logic [DATA_W-1:0] lookup_req_tdata, lookup_rsp_tdata;
  logic              lookup_req_tvalid, lookup_req_tready;
  logic              lookup_rsp_tvalid, lookup_rsp_tready;
  logic [DATA_W-1:0] out_read_tdata, out_write_tdata;
  logic              out_read_tvalid, out_read_tready, out_write_tvalid, out_write_tready;
  logic              cfg_pause, idle, err_unexp_rsp;
  logic [CNT_W-1:0]  outstanding;

  int n_cmp  = 0;
  int n_fail = 0;
  int accepted;

  mapping_req_arbiter dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .in_read_tdata     (in_read_tdata),
    .in_read_tvalid    (in_read_tvalid),
    .in_read_tready    (in_read_tready),
    .in_write_tdata    (in_write_tdata),
    .in_write_tvalid   (in_write_tvalid),
    .in_write_tready   (in_write_tready),
    .lookup_req_tdata  (lookup_req_tdata),
    .lookup_req_tvalid (lookup_req_tvalid),
    .lookup_req_tready (lookup_req_tready),
    .lookup_rsp_tdata  (lookup_rsp_tdata),
    .lookup_rsp_tvalid (lookup_rsp_tvalid),
    .lookup_rsp_tready (lookup_rsp_tready),
    .out_read_tdata    (out_read_tdata),
    .out_read_tvalid   (out_read_tvalid),
    .out_read_tready   (out_read_tready),
    .out_write_tdata   (out_write_tdata),
    .out_write_tvalid  (out_write_tvalid),
    .out_write_tready  (out_write_tready),
    .cfg_pause         (cfg_pause),
    .idle              (idle),
    .outstanding       (outstanding),
    .err_unexp_rsp     (err_unexp_rsp)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_read_tdata     = '0;
    in_read_tvalid    = 1'b0;
    in_write_tdata    = '0;
    in_write_tvalid   = 1'b0;
    lookup_req_tready = 1'b0;
    lookup_rsp_tdata  = '0;
    lookup_rsp_tvalid = 1'b0;
    out_read_tready   = 1'b0;
    out_write_tready  = 1'b0;
    cfg_pause         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    #1;
    chk("rst_req_tvalid", lookup_req_tvalid, 0);
    chk("rst_req_tdata", lookup_req_tdata, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err_unexp_rsp, 0);
  endtask

  initial begin
    clear_inputs();
    ap_rst_n = 1'b0;
    // tready outputs must stay low while reset is held, even with traffic offered
    in_read_tvalid    = 1'b1;
    in_write_tvalid   = 1'b1;
    lookup_rsp_tvalid = 1'b1;
    out_read_tready   = 1'b1;
    tick();
    chk("inrst_rd_tready", in_read_tready, 0);
    chk("inrst_wr_tready", in_write_tready, 0);
    chk("inrst_rsp_tready", lookup_rsp_tready, 0);
    do_reset();

    // 1: single read round trip
    in_read_tdata  = 72'h00_0000_0000_0000_1000;
    in_read_tvalid = 1'b1;
    #1;
    chk("t1_rd_tready", in_read_tready, 1);
    chk("t1_wr_tready", in_write_tready, 0);
    tick();
    in_read_tvalid = 1'b0;
    chk("t1_req_tvalid", lookup_req_tvalid, 1);
    chk("t1_req_tdata", lookup_req_tdata, 72'h1000);
    chk("t1_outst1", outstanding, 1);
    chk("t1_idle0", idle, 0);
    lookup_req_tready = 1'b1;
    tick();
    chk("t1_req_drained", lookup_req_tvalid, 0);
    lookup_rsp_tdata  = 72'hAB;
    lookup_rsp_tvalid = 1'b1;
    out_read_tready   = 1'b1;
    #1;
    chk("t1_out_rd_tvalid", out_read_tvalid, 1);
    chk("t1_out_rd_tdata", out_read_tdata, 72'hAB);
    chk("t1_out_wr_tvalid", out_write_tvalid, 0);
    chk("t1_rsp_tready", lookup_rsp_tready, 1);
    tick();
    lookup_rsp_tvalid = 1'b0;
    chk("t1_outst0", outstanding, 0);
    chk("t1_idle1", idle, 1);

    // 2: both valid, grants alternate starting with read; responses steered in order
    do_reset();
    lookup_req_tready = 1'b1;
    in_read_tvalid    = 1'b1;
    in_write_tvalid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_read_tdata  = 72'h100 + 72'(i);
      in_write_tdata = 72'h200 + 72'(i);
      #1;
      chk("t2_rd_grant", in_read_tready, (i % 2 == 0) ? 1 : 0);
      chk("t2_wr_grant", in_write_tready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_req_tdata", lookup_req_tdata, (i % 2 == 0) ? 72'h100 + 72'(i) : 72'h200 + 72'(i));
      chk("t2_req_tvalid", lookup_req_tvalid, 1);
    end
    in_read_tvalid  = 1'b0;
    in_write_tvalid = 1'b0;
    chk("t2_outst8", outstanding, 8);
    tick();
    lookup_rsp_tvalid = 1'b1;
    out_read_tready   = 1'b1;
    out_write_tready  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      lookup_rsp_tdata = 72'hC0 + 72'(j);
      #1;
      chk("t2_out_rd_tvalid", out_read_tvalid, (j % 2 == 0) ? 1 : 0);
      chk("t2_out_wr_tvalid", out_write_tvalid, (j % 2 == 1) ? 1 : 0);
      chk("t2_out_tdata", (j % 2 == 0) ? out_read_tdata : out_write_tdata, 72'hC0 + 72'(j));
      tick();
    end
    lookup_rsp_tvalid = 1'b0;
    chk("t2_outst0", outstanding, 0);

    // 3: outstanding limit of 16
    do_reset();
    lookup_req_tready = 1'b1;
    in_read_tvalid    = 1'b1;
    accepted          = 0;
    for (int k = 0; k < 20; k++) begin
      in_read_tdata = 72'h300 + 72'(k);
      #1;
      if (in_read_tready) accepted++;
      tick();
    end
    chk("t3_accepted", 72'(accepted), 16);
    chk("t3_outst16", outstanding, 16);
    chk("t3_full_tready", in_read_tready, 0);
    lookup_rsp_tvalid = 1'b1;
    out_read_tready   = 1'b1;
    #1;
    chk("t3_rsp_tready", lookup_rsp_tready, 1);
    chk("t3_same_cycle_blocked", in_read_tready, 0);
    tick();
    lookup_rsp_tvalid = 1'b0;
    #1;
    chk("t3_outst15", outstanding, 15);
    chk("t3_unblocked", in_read_tready, 1);
    in_read_tvalid = 1'b0;
    do_reset();

    // 4: held request stays stable under backpressure, then back-to-back issue
    in_read_tdata  = 72'hAA1;
    in_read_tvalid = 1'b1;
    tick();
    in_read_tdata = 72'hAA2;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t4_stall_tready", in_read_tready, 0);
      chk("t4_stall_tdata", lookup_req_tdata, 72'hAA1);
      chk("t4_stall_tvalid", lookup_req_tvalid, 1);
      tick();
    end
    lookup_req_tready = 1'b1;
    #1;
    chk("t4_resume_tready", in_read_tready, 1);
    tick();
    chk("t4_b2b_tdata1", lookup_req_tdata, 72'hAA2);
    in_read_tdata = 72'hAA3;
    tick();
    chk("t4_b2b_tdata2", lookup_req_tdata, 72'hAA3);
    chk("t4_b2b_tvalid", lookup_req_tvalid, 1);
    in_read_tvalid = 1'b0;

    // 5: write at FIFO head blocks a following read response
    do_reset();
    lookup_req_tready = 1'b1;
    in_write_tdata    = 72'h500;
    in_write_tvalid   = 1'b1;
    tick();
    in_write_tvalid = 1'b0;
    in_read_tdata   = 72'h501;
    in_read_tvalid  = 1'b1;
    tick();
    in_read_tvalid = 1'b0;
    tick();
    chk("t5_outst2", outstanding, 2);
    lookup_rsp_tvalid = 1'b1;
    lookup_rsp_tdata  = 72'h5A;
    out_read_tready   = 1'b1;
    out_write_tready  = 1'b0;
    #1;
    chk("t5_rsp_tready_blk", lookup_rsp_tready, 0);
    chk("t5_no_overtake", out_read_tvalid, 0);
    chk("t5_wr_tvalid", out_write_tvalid, 1);
    tick();
    chk("t5_outst_held", outstanding, 2);
    out_write_tready = 1'b1;
    #1;
    chk("t5_rsp_tready_go", lookup_rsp_tready, 1);
    tick();
    chk("t5_rd_next", out_read_tvalid, 1);
    chk("t5_wr_next", out_write_tvalid, 0);
    tick();
    lookup_rsp_tvalid = 1'b0;
    chk("t5_outst0", outstanding, 0);

    // 6a: unexpected response with empty FIFO sets a sticky error
    lookup_rsp_tvalid = 1'b1;
    #1;
    chk("t6_unexp_tready", lookup_rsp_tready, 0);
    chk("t6_unexp_out_rd", out_read_tvalid, 0);
    tick();
    lookup_rsp_tvalid = 1'b0;
    chk("t6_err_set", err_unexp_rsp, 1);
    tick();
    tick();
    chk("t6_err_sticky", err_unexp_rsp, 1);

    // 6b: pause with 3 outstanding, drain to idle
    do_reset();
    lookup_req_tready = 1'b1;
    in_read_tvalid    = 1'b1;
    for (int m = 0; m < 3; m++) begin
      in_read_tdata = 72'h600 + 72'(m);
      tick();
    end
    in_read_tvalid = 1'b0;
    tick();
    chk("t6_outst3", outstanding, 3);
    cfg_pause       = 1'b1;
    in_read_tvalid  = 1'b1;
    in_write_tvalid = 1'b1;
    tick();
    chk("t6_pause_rd", in_read_tready, 0);
    chk("t6_pause_wr", in_write_tready, 0);
    tick();
    chk("t6_pause_outst", outstanding, 3);
    chk("t6_pause_idle0", idle, 0);
    lookup_rsp_tvalid = 1'b1;
    out_read_tready   = 1'b1;
    for (int r = 0; r < 3; r++) tick();
    lookup_rsp_tvalid = 1'b0;
    chk("t6_drain_outst", outstanding, 0);
    chk("t6_drain_idle", idle, 1);
    chk("t6_still_paused", in_read_tready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
